fp_add_pipe: RTL

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_add_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with ready/valid flow control.
// Denormal operands flush to zero; overflow saturates to all ones, underflow flushes to signed zero.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] z,
   output logic                 ovf,
   output logic                 unf
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int AW = MAN_W + 3;
   localparam int SW = MAN_W + 5;
   localparam int NW = MAN_W + 4;
   localparam int XW = EXP_W + 2;
   localparam int LW = $clog2(NW + 1);
   localparam int WW = 2 * MAN_W + 6;
   localparam logic [EXP_W-1:0]        EMAX   = '1;
   localparam logic signed [XW-1:0]    X_ZERO = '0;
   localparam logic signed [XW-1:0]    X_EMAX = {2'b00, EMAX};

   function automatic logic [LW-1:0] f_lzc(input logic [NW-1:0] v);
      logic [LW-1:0] n;
      n = LW'(NW);
      for (int i = 0; i < NW; i++)
         if (v[i]) n = LW'(NW - 1 - i);
      return n;
   endfunction

   // n = {hidden, mantissa, G, R, S}; result = {carry, hidden, mantissa}
   function automatic logic [MAN_W+1:0] f_round(input logic [NW-1:0] n);
      logic up;
      up = n[2] & (n[3] | n[1] | n[0]);
      return {1'b0, n[NW-1:3]} + (MAN_W+2)'(up);
   endfunction

   // Returns {ovf, unf, z}; en is the normalized exponent, ef the exponent after rounding.
   function automatic logic [W+1:0] f_sat(input logic s, input logic signed [XW-1:0] en,
                                          input logic signed [XW-1:0] ef, input logic [MAN_W-1:0] m);
      if (en <= X_ZERO) return {2'b01, s, {(W-1){1'b0}}};
      if (ef >= X_EMAX) return {2'b10, {W{1'b1}}};
      return {2'b00, s, ef[EXP_W-1:0], m};
   endfunction

   logic                 advance;
   logic                 sa, sbe, za, zb, swap, z_sml;
   logic [EXP_W-1:0]     ea, eb, e_big, e_sml, shamt;
   logic [MAN_W-1:0]     m_big, m_sml;
   logic [WW-1:0]        wide;
   logic                 vld_p1_d, sign_p1_d, esub_p1_d, stk_p1_d, bz_p1_d, zs_p1_d, inf_p1_d;
   logic [EXP_W-1:0]     exp_p1_d;
   logic [AW-1:0]        mbig_p1_d, msml_p1_d;
   logic                 vld_p1_q, sign_p1_q, esub_p1_q, stk_p1_q, bz_p1_q, zs_p1_q, inf_p1_q;
   logic [EXP_W-1:0]     exp_p1_q;
   logic [AW-1:0]        mbig_p1_q, msml_p1_q;
   logic [SW-1:0]        opa, opb;
   logic                 vld_p2_d, sign_p2_d, bz_p2_d, zs_p2_d, inf_p2_d;
   logic [EXP_W-1:0]     exp_p2_d;
   logic [SW-1:0]        sum_p2_d;
   logic                 vld_p2_q, sign_p2_q, bz_p2_q, zs_p2_q, inf_p2_q;
   logic [EXP_W-1:0]     exp_p2_q;
   logic [SW-1:0]        sum_p2_q;
   logic [LW-1:0]        lz;
   logic [NW-1:0]        norm;
   logic signed [XW-1:0] expn, expf;
   logic [MAN_W+1:0]     rnd;
   logic [MAN_W-1:0]     man_r;
   logic [W+1:0]         res;
   logic                 vld_p3_d, ovf_d, unf_d;
   logic [W-1:0]         z_d;
   logic                 vld_p3_q, ovf_q, unf_q;
   logic [W-1:0]         z_q;

   assign advance   = out_ready | ~vld_p3_q;
   assign in_ready  = advance;
   assign out_valid = vld_p3_q;
   assign z         = z_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

   // Stage 1: unpack, order by magnitude, align the smaller operand
   always_comb begin
      sa    = a[W-1];
      sbe   = b[W-1] ^ sub;
      ea    = a[W-2:MAN_W];
      eb    = b[W-2:MAN_W];
      za    = (ea == '0);
      zb    = (eb == '0);
      swap  = (zb ? '0 : b[W-2:0]) > (za ? '0 : a[W-2:0]);
      e_big = swap ? eb : ea;
      e_sml = swap ? ea : eb;
      m_big = swap ? b[MAN_W-1:0] : a[MAN_W-1:0];
      m_sml = swap ? a[MAN_W-1:0] : b[MAN_W-1:0];
      z_sml = swap ? za : zb;
      shamt = e_big - e_sml;
      wide  = {1'b1, m_sml, {(MAN_W+5){1'b0}}} >> shamt;
      msml_p1_d = '0;
      stk_p1_d  = 1'b0;
      if (z_sml) begin
         msml_p1_d = '0;
         stk_p1_d  = 1'b0;
      end else if (int'(shamt) > AW) begin
         msml_p1_d = '0;
         stk_p1_d  = 1'b1;
      end else begin
         msml_p1_d = wide[WW-1 -: AW];
         stk_p1_d  = |wide[WW-AW-1:0];
      end
      vld_p1_d  = in_valid;
      sign_p1_d = swap ? sbe : sa;
      esub_p1_d = sa ^ sbe;
      exp_p1_d  = e_big;
      mbig_p1_d = {1'b1, m_big, 2'b00};
      bz_p1_d   = za & zb;
      zs_p1_d   = sa & sbe;
      inf_p1_d  = (ea == EMAX) | (eb == EMAX);
   end

   // Stage 2: magnitude add/subtract, sticky enters as the LSB so borrows propagate
   always_comb begin
      opa       = {1'b0, mbig_p1_q, 1'b0};
      opb       = {1'b0, msml_p1_q, stk_p1_q};
      sum_p2_d  = esub_p1_q ? (opa - opb) : (opa + opb);
      vld_p2_d  = vld_p1_q;
      sign_p2_d = sign_p1_q;
      exp_p2_d  = exp_p1_q;
      bz_p2_d   = bz_p1_q;
      zs_p2_d   = zs_p1_q;
      inf_p2_d  = inf_p1_q;
   end

   // Stage 3: normalize, round to nearest even, pack with saturation
   always_comb begin
      lz = f_lzc(sum_p2_q[NW-1:0]);
      if (sum_p2_q[SW-1]) begin
         norm = {sum_p2_q[SW-1:2], sum_p2_q[1] | sum_p2_q[0]};
         expn = $signed({2'b00, exp_p2_q} + XW'(1));
      end else begin
         norm = sum_p2_q[NW-1:0] << lz;
         expn = $signed({2'b00, exp_p2_q} - XW'(lz));
      end
      rnd   = f_round(norm);
      man_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      expf  = expn + $signed({{(XW-1){1'b0}}, rnd[MAN_W+1]});
      if (inf_p2_q)             res = {2'b10, {W{1'b1}}};
      else if (bz_p2_q)         res = {2'b00, zs_p2_q, {(W-1){1'b0}}};
      else if (sum_p2_q == '0)  res = '0;
      else                      res = f_sat(sign_p2_q, expn, expf, man_r);
      vld_p3_d = vld_p2_q;
      ovf_d    = res[W+1];
      unf_d    = res[W];
      z_d      = res[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         z_q      <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else if (advance) begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
         z_q      <= z_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         sign_p1_q <= sign_p1_d;
         esub_p1_q <= esub_p1_d;
         stk_p1_q  <= stk_p1_d;
         bz_p1_q   <= bz_p1_d;
         zs_p1_q   <= zs_p1_d;
         inf_p1_q  <= inf_p1_d;
         exp_p1_q  <= exp_p1_d;
         mbig_p1_q <= mbig_p1_d;
         msml_p1_q <= msml_p1_d;
         sign_p2_q <= sign_p2_d;
         bz_p2_q   <= bz_p2_d;
         zs_p2_q   <= zs_p2_d;
         inf_p2_q  <= inf_p2_d;
         exp_p2_q  <= exp_p2_d;
         sum_p2_q  <= sum_p2_d;
      end
   end
endmodule
